// File: rtl/ram_io_responder_if.sv
// CPU byte-bus bundle between the core (master) and the memory-side responder (slave).
interface ram_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (output mem_a, output mem_dout, output mem_wr,
                    input  mem_din, input io_buffer_full);
    modport slave  (input  mem_a, input mem_dout, input mem_wr,
                    output mem_din, output io_buffer_full);
endinterface

// File: rtl/ram_io_responder.sv
// Memory-side responder for the CPU byte bus: RAM/IO decode, one-cycle read return,
// UART TX FIFO, RX pop strobe, free-running cycle counter and program-stop flag.
module ram_io_responder #(
    parameter int RAM_AW     = 17,
    parameter int TXF_DEPTH  = 8,
    parameter int FULL_SLACK = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    ram_io_responder_if.slave bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_done,
    output logic              drained
);
    localparam int PTR_W = $clog2(TXF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TXF_DEPTH);
    localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(FULL_SLACK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_RX   = 3'd1,
        SEL_CNT0 = 3'd2,
        SEL_CNT1 = 3'd3,
        SEL_CNT2 = 3'd4,
        SEL_CNT3 = 3'd5,
        SEL_ZERO = 3'd6
    } sel_e;

    sel_e             r_sel;
    logic [7:0]       r_byte;
    logic             r_live;
    logic [31:0]      r_cnt;
    logic [31:0]      r_snap;
    logic             r_done;
    logic             r_drained;
    logic             r_full;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_mem [TXF_DEPTH];

    logic             w_is_io;
    logic [15:0]      w_off;
    logic             w_io_rd;
    logic             w_io_wr;
    sel_e             w_sel_nxt;
    logic [7:0]       w_byte_nxt;
    logic [31:0]      w_snap_nxt;
    logic             w_rx_pop;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_unused_addr;

    assign ram_addr      = bus.mem_a[RAM_AW-1:0];
    assign ram_we        = bus.mem_wr && !w_is_io;
    assign ram_wdata     = bus.mem_dout;
    assign w_unused_addr = ^bus.mem_a[31:18];

    // The RAM path only drives the bus once a real access has been registered since reset.
    assign bus.mem_din        = (r_sel == SEL_RAM && r_live) ? ram_rdata : r_byte;
    assign bus.io_buffer_full = r_full;
    assign tx_valid           = (r_count != CNT_ZERO);
    assign tx_data            = r_mem[r_rd_ptr];
    assign rx_ready           = w_rx_pop && rst_in;
    assign prog_done          = r_done;
    assign drained            = r_drained;

    // Address decode and selection of the byte returned on the next cycle.
    always_comb begin
        w_is_io    = (bus.mem_a[17:16] == 2'b11);
        w_off      = bus.mem_a[15:0];
        w_io_rd    = w_is_io && !bus.mem_wr;
        w_io_wr    = w_is_io && bus.mem_wr;
        w_sel_nxt  = SEL_ZERO;
        w_byte_nxt = 8'h00;
        w_snap_nxt = r_snap;
        w_rx_pop   = 1'b0;
        if (w_io_rd) begin
            case (w_off)
                16'h0000: begin
                    w_sel_nxt = SEL_RX;
                    if (rx_valid) begin
                        w_byte_nxt = rx_data;
                        w_rx_pop   = 1'b1;
                    end else begin
                        w_byte_nxt = 8'h00;
                    end
                end
                16'h0004: begin
                    w_sel_nxt  = SEL_CNT0;
                    w_snap_nxt = r_cnt;
                    w_byte_nxt = r_cnt[7:0];
                end
                16'h0005: begin
                    w_sel_nxt  = SEL_CNT1;
                    w_byte_nxt = r_snap[15:8];
                end
                16'h0006: begin
                    w_sel_nxt  = SEL_CNT2;
                    w_byte_nxt = r_snap[23:16];
                end
                16'h0007: begin
                    w_sel_nxt  = SEL_CNT3;
                    w_byte_nxt = r_snap[31:24];
                end
                default: begin
                    w_sel_nxt  = SEL_ZERO;
                    w_byte_nxt = 8'h00;
                end
            endcase
        end else if (!bus.mem_wr) begin
            w_sel_nxt = SEL_RAM;
        end else begin
            w_sel_nxt = SEL_ZERO;
        end
    end

    // TX FIFO push/pop; a push into a full FIFO is only taken when a pop frees a slot.
    always_comb begin
        w_pop      = tx_valid && tx_ready;
        w_push     = w_io_wr && (w_off == 16'h0000) && (bus.mem_dout != 8'h00)
                     && ((r_count != DEPTH_C) || w_pop);
        w_done_nxt = r_done || (w_io_wr && (w_off == 16'h0004));
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Read-return registers, cycle counter, snapshot and program-stop flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sel  <= SEL_RAM;
            r_byte <= 8'h00;
            r_live <= 1'b0;
            r_cnt  <= 32'h0000_0000;
            r_snap <= 32'h0000_0000;
            r_done <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_byte <= w_byte_nxt;
            r_live <= 1'b1;
            r_cnt  <= r_cnt + 32'h0000_0001;
            r_snap <= w_snap_nxt;
            r_done <= w_done_nxt;
        end
    end

    // TX FIFO storage, pointers, occupancy and the flags derived from next occupancy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= CNT_ZERO;
            r_full    <= 1'b0;
            r_drained <= 1'b0;
            for (int i = 0; i < TXF_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.mem_dout;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count   <= w_count_nxt;
            r_full    <= ((DEPTH_C - w_count_nxt) <= SLACK_C);
            r_drained <= w_done_nxt && (w_count_nxt == CNT_ZERO);
        end
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// Randomized and directed bench for ram_io_responder against a queue/array reference model.
module tb_ram_io_responder;
    localparam int RAM_AW = 17;
    localparam int DEPTH  = 8;
    localparam int SLACK  = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              prog_done;
    logic              drained;

    ram_io_responder_if bus ();

    ram_io_responder #(.RAM_AW(RAM_AW), .TXF_DEPTH(DEPTH), .FULL_SLACK(SLACK)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .bus       (bus.slave),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .prog_done (prog_done),
        .drained   (drained)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural synchronous RAM attached to the responder.
    bit [7:0] ram_arr [0:(1<<RAM_AW)-1];
    always @(posedge clk_in) begin
        if (ram_we) ram_arr[ram_addr] <= ram_wdata;
        ram_rdata <= ram_arr[ram_addr];
    end

    // Reference model state.
    bit   [7:0]  ref_ram [0:(1<<RAM_AW)-1];
    logic [7:0]  m_q [$];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_done;
    logic [7:0]  exp_din;
    logic        exp_full;
    logic        exp_drained;
    logic [7:0]  last_din;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt       = 32'd0;
        m_snap      = 32'd0;
        m_done      = 1'b0;
        exp_din     = 8'h00;
        exp_full    = 1'b0;
        exp_drained = 1'b0;
    endtask

    // One bus cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
        logic       is_io;
        logic [15:0] off;
        logic       pop;
        logic       push;
        logic [7:0] nd;
        last_din = bus.mem_din;
        chk("mem_din", bus.mem_din, exp_din);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
        chk("io_buffer_full", bus.io_buffer_full, exp_full);
        chk("prog_done", prog_done, m_done);
        chk("drained", drained, exp_drained);

        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
        tx_ready     = txr;
        rx_valid     = rxv;
        rx_data      = rxd;
        #1;
        is_io = (a[17:16] == 2'b11);
        off   = a[15:0];
        chk("ram_we", ram_we, wr && !is_io);
        chk("rx_ready", rx_ready, !wr && is_io && off == 16'h0000 && rxv);

        pop  = (m_q.size() != 0) && txr;
        push = 1'b0;
        nd   = 8'h00;
        if (wr) begin
            if (!is_io) ref_ram[a[RAM_AW-1:0]] = d;
            else if (off == 16'h0000 && d != 8'h00 && (m_q.size() < DEPTH || pop)) push = 1'b1;
            else if (off == 16'h0004) m_done = 1'b1;
        end else if (!is_io) begin
            nd = ref_ram[a[RAM_AW-1:0]];
        end else begin
            case (off)
                16'h0000: nd = rxv ? rxd : 8'h00;
                16'h0004: begin m_snap = m_cnt; nd = m_cnt[7:0]; end
                16'h0005: nd = m_snap[15:8];
                16'h0006: nd = m_snap[23:16];
                16'h0007: nd = m_snap[31:24];
                default:  nd = 8'h00;
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(d);
        m_cnt       = m_cnt + 32'd1;
        exp_din     = nd;
        exp_full    = (DEPTH - m_q.size()) <= SLACK;
        exp_drained = m_done && (m_q.size() == 0);
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n, input logic txr);
        for (int i = 0; i < n; i++) step(32'h0003_0008, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    // Asynchronous reset applied between edges with a pending IO read and RX data present.
    task automatic do_reset();
        bus.mem_a  = 32'h0003_0000;
        bus.mem_wr = 1'b0;
        rx_valid   = 1'b1;
        rx_data    = 8'h5A;
        tx_ready   = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        chk("rst mem_din", bus.mem_din, 8'h00);
        chk("rst io_buffer_full", bus.io_buffer_full, 1'b0);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst rx_ready", rx_ready, 1'b0);
        chk("rst prog_done", prog_done, 1'b0);
        chk("rst drained", drained, 1'b0);
        @(posedge clk_in);
        #1;
        chk("rst hold mem_din", bus.mem_din, 8'h00);
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic rand_phase(input int n);
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, 63));
                4, 5:       a = 32'h0003_0000;
                6:          a = 32'h0003_0004 + 32'($urandom_range(0, 3));
                7:          a = 32'h0003_0008;
                default:    a = 32'h0001_0000 + 32'($urandom_range(0, 15));
            endcase
            wr = ($urandom_range(0, 2) == 0);
            if (wr && a == 32'h0003_0004 && $urandom_range(0, 7) != 0) wr = 1'b0;
            d  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            step(a, wr, d, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        logic [31:0] word;
        rst_in       = 1'b0;
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        @(posedge clk_in);
        #1;
        do_reset();

        // RAM write then read-back one cycle later.
        step(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        idle(1, 1'b0);
        chk("ram readback", last_din, 8'hA5);

        // TX pushes with a zero byte that must be ignored, then drain.
        step(32'h0003_0000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
        step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        step(32'h0003_0000, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
        idle(4, 1'b1);

        // Fill past full: near-full flag, drop on overflow, single pop keeps flag.
        for (int i = 1; i <= 9; i++) step(32'h0003_0000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("full after one pop", bus.io_buffer_full, 1'b1);
        idle(10, 1'b1);

        // RX pop with and without data.
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99);
        chk("rx byte", last_din, 8'h37);
        idle(1, 1'b0);

        // Coherent 4-byte counter snapshot after ~300 cycles.
        while (m_cnt < 32'd300) idle(1, 1'b0);
        word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step(32'h0003_0004 + 32'(k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            if (k > 0) word[(k-1)*8 +: 8] = last_din;
        end
        idle(1, 1'b0);
        word[31:24] = last_din;
        chk("snapshot word", word, m_snap);

        // Program stop with bytes queued; drained follows the last pop.
        for (int i = 0; i < 3; i++) step(32'h0003_0000, 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0, 8'h00);
        step(32'h0003_0004, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
        idle(1, 1'b0);
        chk("prog_done set", prog_done, 1'b1);
        chk("not drained yet", drained, 1'b0);
        idle(4, 1'b1);
        chk("drained after pops", drained, 1'b1);

        rand_phase(700);
        do_reset();
        rand_phase(700);
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
